// File: rtl/win_defs_pkg.sv
// Shared definitions for the register-window controller: FSM encoding,
// window/register constants, default spill stack base and window arithmetic.
package win_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPILL0 = 3'd1,
        ST_SPILL1 = 3'd2,
        ST_FILL1  = 3'd3,
        ST_FILL0  = 3'd4
    } win_state_t;

    localparam logic [1:0] W0 = 2'b00;
    localparam logic [1:0] W1 = 2'b01;
    localparam logic [1:0] W2 = 2'b10;
    localparam logic [1:0] W3 = 2'b11;

    localparam logic [1:0] REG_LOCAL0 = 2'd0;
    localparam logic [1:0] REG_LOCAL1 = 2'd1;

    localparam logic [15:0] DEFAULT_SPILL_BASE = 16'hFF00;

    // The oldest resident window sits RES-1 windows below CWP, modulo 4.
    function automatic logic [1:0] oldest_window(input logic [1:0] cwp, input logic [1:0] res);
        logic [1:0] w;
        case (res)
            2'd2:    w = cwp + W3;
            2'd3:    w = cwp + W2;
            default: w = cwp + W0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/win_spill_fsm.sv
// Spill/fill sequencer: two-cycle spill of the oldest window's locals to
// memory, two-cycle fill of the window below CWP, with regfile/memory decode.
module win_spill_fsm
    import win_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_spill,
    input  logic        start_fill,
    input  logic [1:0]  cwp,
    input  logic [1:0]  res,
    input  logic [15:0] sp,
    input  logic [15:0] rf_rdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        spill_done,
    output logic        fill_done,
    output logic [1:0]  window,
    output logic        rf_sel,
    output logic [1:0]  rf_reg,
    output logic        rf_wen,
    output logic [15:0] rf_wdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] mem_wdata
);

    win_state_t state_reg;
    win_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        spill_done = 1'b0;
        fill_done  = 1'b0;
        window     = W0;
        rf_sel     = 1'b0;
        rf_reg     = REG_LOCAL0;
        rf_wen     = 1'b0;
        rf_wdata   = 16'h0000;
        mem_addr   = 16'h0000;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wdata  = 16'h0000;
        case (state_reg)
            ST_IDLE: begin
                if (start_spill) begin
                    state_next = ST_SPILL0;
                end else if (start_fill) begin
                    state_next = ST_FILL1;
                end
            end
            ST_SPILL0: begin
                busy       = 1'b1;
                window     = oldest_window(cwp, res);
                rf_sel     = 1'b1;
                rf_reg     = REG_LOCAL0;
                mem_we     = 1'b1;
                mem_addr   = sp;
                mem_wdata  = rf_rdata;
                state_next = ST_SPILL1;
            end
            ST_SPILL1: begin
                busy       = 1'b1;
                spill_done = 1'b1;
                window     = oldest_window(cwp, res);
                rf_sel     = 1'b1;
                rf_reg     = REG_LOCAL1;
                mem_we     = 1'b1;
                mem_addr   = sp + 16'd1;
                mem_wdata  = rf_rdata;
                state_next = ST_IDLE;
            end
            // Fill restores in reverse order: local1 (top of stack) first.
            ST_FILL1: begin
                busy       = 1'b1;
                window     = cwp + W3;
                rf_sel     = 1'b1;
                rf_reg     = REG_LOCAL1;
                rf_wen     = 1'b1;
                rf_wdata   = mem_rdata;
                mem_re     = 1'b1;
                mem_addr   = sp - 16'd1;
                state_next = ST_FILL0;
            end
            ST_FILL0: begin
                busy       = 1'b1;
                fill_done  = 1'b1;
                window     = cwp + W3;
                rf_sel     = 1'b1;
                rf_reg     = REG_LOCAL0;
                rf_wen     = 1'b1;
                rf_wdata   = mem_rdata;
                mem_re     = 1'b1;
                mem_addr   = sp - 16'd2;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window controller: CWP/residency/spill-stack bookkeeping around the
// spill/fill sequencer. Define WINCTRL_STATS_EN to add spill/fill counters.
module reg_window_ctrl
    import win_defs_pkg::*;
#(
    parameter int          MAX_RES    = 3,
    parameter logic [15:0] SPILL_BASE = DEFAULT_SPILL_BASE,
    parameter int          SPILL_MAX  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        call_i,
    input  logic        ret_i,
    output logic        stall_o,
    output logic [1:0]  window_o,
    output logic        rf_sel_o,
    output logic [1:0]  rf_reg_o,
    output logic        rf_wen_o,
    output logic [15:0] rf_wdata_o,
    input  logic [15:0] rf_rdata_i,
    output logic [15:0] mem_addr_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    output logic        err_o
`ifdef WINCTRL_STATS_EN
    ,
    output logic [15:0] spill_cnt_o,
    output logic [15:0] fill_cnt_o
`endif
);

    localparam int                 DEPTH_W   = $clog2(SPILL_MAX + 1);
    localparam logic [1:0]         RES_MAX   = 2'(MAX_RES);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(SPILL_MAX);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    logic [1:0]         cwp_reg;
    logic [1:0]         res_reg;
    logic [15:0]        sp_reg;
    logic [DEPTH_W-1:0] depth_reg;
    logic               err_reg;

    logic busy;
    logic spill_done;
    logic fill_done;
    logic [1:0] fsm_window;

    logic call_only;
    logic ret_only;
    logic res_full;
    logic res_single;
    logic stack_full;
    logic stack_empty;
    logic do_call;
    logic do_ret;
    logic start_spill;
    logic start_fill;
    logic err_set;

    // Simultaneous call and ret cancel out; nothing is decoded outside IDLE.
    assign call_only   = call_i & ~ret_i & ~busy;
    assign ret_only    = ret_i & ~call_i & ~busy;
    assign res_full    = (res_reg == RES_MAX);
    assign res_single  = (res_reg == 2'd1);
    assign stack_full  = (depth_reg == DEPTH_MAX);
    assign stack_empty = (depth_reg == '0);

    assign do_call     = call_only & ~res_full;
    assign do_ret      = ret_only & ~res_single;
    assign start_spill = call_only & res_full & ~stack_full;
    assign start_fill  = ret_only & res_single & ~stack_empty;
    assign err_set     = (call_only & res_full & stack_full) |
                         (ret_only & res_single & stack_empty);

    win_spill_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start_spill (start_spill),
        .start_fill  (start_fill),
        .cwp         (cwp_reg),
        .res         (res_reg),
        .sp          (sp_reg),
        .rf_rdata    (rf_rdata_i),
        .mem_rdata   (mem_rdata_i),
        .busy        (busy),
        .spill_done  (spill_done),
        .fill_done   (fill_done),
        .window      (fsm_window),
        .rf_sel      (rf_sel_o),
        .rf_reg      (rf_reg_o),
        .rf_wen      (rf_wen_o),
        .rf_wdata    (rf_wdata_o),
        .mem_addr    (mem_addr_o),
        .mem_we      (mem_we_o),
        .mem_re      (mem_re_o),
        .mem_wdata   (mem_wdata_o)
    );

    assign stall_o  = start_spill | start_fill | busy;
    assign window_o = busy ? fsm_window : cwp_reg;
    assign err_o    = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cwp_reg   <= W0;
            res_reg   <= 2'd1;
            sp_reg    <= SPILL_BASE;
            depth_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (do_call) begin
                cwp_reg <= cwp_reg + W1;
                res_reg <= res_reg + 2'd1;
            end else if (do_ret) begin
                cwp_reg <= cwp_reg + W3;
                res_reg <= res_reg - 2'd1;
            end else if (spill_done) begin
                sp_reg    <= sp_reg + 16'd2;
                depth_reg <= depth_reg + DEPTH_ONE;
                res_reg   <= res_reg - 2'd1;
            end else if (fill_done) begin
                sp_reg    <= sp_reg - 16'd2;
                depth_reg <= depth_reg - DEPTH_ONE;
                res_reg   <= res_reg + 2'd1;
            end
        end
    end

`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_cnt_reg;
    logic [15:0] fill_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spill_cnt_reg <= 16'h0000;
            fill_cnt_reg  <= 16'h0000;
        end else begin
            if (spill_done && (spill_cnt_reg != 16'hFFFF)) begin
                spill_cnt_reg <= spill_cnt_reg + 16'd1;
            end
            if (fill_done && (fill_cnt_reg != 16'hFFFF)) begin
                fill_cnt_reg <= fill_cnt_reg + 16'd1;
            end
        end
    end

    assign spill_cnt_o = spill_cnt_reg;
    assign fill_cnt_o  = fill_cnt_reg;
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: per-cycle model of window/stack behaviour plus
// directed call/ret sequences with literal expectations.
module tb_reg_window_ctrl;

    localparam logic [15:0] BASE      = 16'hFF00;
    localparam int          MAXRES    = 3;
    localparam int          SPILLMAX  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        call_i;
    logic        ret_i;
    logic        stall_o;
    logic [1:0]  window_o;
    logic        rf_sel_o;
    logic [1:0]  rf_reg_o;
    logic        rf_wen_o;
    logic [15:0] rf_wdata_o;
    logic [15:0] rf_rdata_i;
    logic [15:0] mem_addr_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        err_o;
`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_cnt_o;
    logic [15:0] fill_cnt_o;
`endif

    always #5 clk = ~clk;

    reg_window_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .stall_o     (stall_o),
        .window_o    (window_o),
        .rf_sel_o    (rf_sel_o),
        .rf_reg_o    (rf_reg_o),
        .rf_wen_o    (rf_wen_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_rdata_i  (rf_rdata_i),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
`ifdef WINCTRL_STATS_EN
        ,
        .spill_cnt_o (spill_cnt_o),
        .fill_cnt_o  (fill_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: windowed regfile view and spill memory.
    logic [15:0] rf_tab [4][2];
    logic [15:0] dmem [64];
    logic [15:0] rd_log [$];

    always_comb rf_rdata_i = rf_tab[window_o][rf_reg_o[0]];
    always_comb mem_rdata_i = dmem[6'(mem_addr_o - BASE)];

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_we_o) dmem[6'(mem_addr_o - BASE)] = mem_wdata_o;
            if (rf_wen_o) rf_tab[window_o][rf_reg_o[0]] = rf_wdata_o;
            if (mem_re_o) rd_log.push_back(mem_addr_o);
        end
    end

    // Model: architectural window state plus a queue of expected busy cycles.
    typedef struct {
        logic        stall;
        logic [1:0]  win;
        logic        sel;
        logic [1:0]  rg;
        logic        wen;
        logic [15:0] rwd;
        logic [15:0] addr;
        logic        we;
        logic        re;
        logic [15:0] mwd;
        int          act;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] stk [$];
    logic [1:0]  m_cwp;
    logic [1:0]  m_res;
    logic [15:0] m_sp;
    int          m_depth;
    logic        m_err;
    int          m_spills;
    int          m_fills;

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] ow;
        logic [31:0] pair;
        if (rst) begin
            check("rst_stall", 32'(stall_o), 0);
            check("rst_window", 32'(window_o), 0);
            check("rst_rf_sel", 32'(rf_sel_o), 0);
            check("rst_mem_we", 32'(mem_we_o), 0);
            check("rst_mem_addr", 32'(mem_addr_o), 0);
            check("rst_err", 32'(err_o), 0);
`ifdef WINCTRL_STATS_EN
            check("rst_spill_cnt", 32'(spill_cnt_o), 0);
            check("rst_fill_cnt", 32'(fill_cnt_o), 0);
`endif
            m_cwp = 2'd0; m_res = 2'd1; m_sp = BASE; m_depth = 0; m_err = 1'b0;
            m_spills = 0; m_fills = 0;
            exp_q.delete();
            stk.delete();
        end else begin
            check("err", 32'(err_o), 32'(m_err));
`ifdef WINCTRL_STATS_EN
            check("spill_cnt", 32'(spill_cnt_o), 32'(m_spills));
            check("fill_cnt", 32'(fill_cnt_o), 32'(m_fills));
`endif
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '{stall: 1'b0, win: m_cwp, sel: 1'b0, rg: 2'd0, wen: 1'b0, rwd: 16'h0,
                      addr: 16'h0, we: 1'b0, re: 1'b0, mwd: 16'h0, act: 0};
                if (call_i && !ret_i) begin
                    if (int'(m_res) < MAXRES) begin
                        m_cwp = m_cwp + 2'd1;
                        m_res = m_res + 2'd1;
                    end else if (m_depth < SPILLMAX) begin
                        e.stall = 1'b1;
                        ow = m_cwp - m_res + 2'd1;
                        exp_q.push_back('{1'b1, ow, 1'b1, 2'd0, 1'b0, 16'h0, m_sp,
                                          1'b1, 1'b0, rf_tab[ow][0], 0});
                        exp_q.push_back('{1'b1, ow, 1'b1, 2'd1, 1'b0, 16'h0, m_sp + 16'd1,
                                          1'b1, 1'b0, rf_tab[ow][1], 1});
                        stk.push_back({rf_tab[ow][1], rf_tab[ow][0]});
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (ret_i && !call_i) begin
                    if (m_res > 2'd1) begin
                        m_cwp = m_cwp - 2'd1;
                        m_res = m_res - 2'd1;
                    end else if (m_depth > 0) begin
                        e.stall = 1'b1;
                        ow = m_cwp - 2'd1;
                        pair = stk.pop_back();
                        exp_q.push_back('{1'b1, ow, 1'b1, 2'd1, 1'b1, pair[31:16], m_sp - 16'd1,
                                          1'b0, 1'b1, 16'h0, 0});
                        exp_q.push_back('{1'b1, ow, 1'b1, 2'd0, 1'b1, pair[15:0], m_sp - 16'd2,
                                          1'b0, 1'b1, 16'h0, 2});
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            check("stall", 32'(stall_o), 32'(e.stall));
            check("window", 32'(window_o), 32'(e.win));
            check("rf_sel", 32'(rf_sel_o), 32'(e.sel));
            check("rf_reg", 32'(rf_reg_o), 32'(e.rg));
            check("rf_wen", 32'(rf_wen_o), 32'(e.wen));
            check("rf_wdata", 32'(rf_wdata_o), 32'(e.rwd));
            check("mem_addr", 32'(mem_addr_o), 32'(e.addr));
            check("mem_we", 32'(mem_we_o), 32'(e.we));
            check("mem_re", 32'(mem_re_o), 32'(e.re));
            check("mem_wdata", 32'(mem_wdata_o), 32'(e.mwd));
            if (e.act == 1) begin
                m_sp = m_sp + 16'd2; m_depth++; m_res = m_res - 2'd1;
                if (m_spills < 65535) m_spills++;
            end else if (e.act == 2) begin
                m_sp = m_sp - 16'd2; m_depth--; m_res = m_res + 2'd1;
                if (m_fills < 65535) m_fills++;
            end
        end
    end

    // Hold call/ret until a cycle without stall completes it; returns stall count.
    task automatic issue(input logic c, input logic r, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        call_i = c;
        ret_i = r;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        call_i = 1'b0;
        ret_i = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue_timeout: got stall still high expected completion within 8 cycles");
        end
        $display("txn call=%0b ret=%0b stalls=%0d window=%0d err=%0b", c, r, stalls, window_o, err_o);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rd_log.delete();
    endtask

    int n;

    initial begin
        rst = 1'b1;
        call_i = 1'b0;
        ret_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 2; r++) rf_tab[w][r] = 16'hA000 + 16'(w * 16 + r);
        end
        for (int i = 0; i < 64; i++) dmem[i] = 16'h0;
        rf_tab[0][0] = 16'h1111;
        rf_tab[0][1] = 16'h2222;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("lit_reset_window", 32'(window_o), 0);
        check("lit_reset_stall", 32'(stall_o), 0);
        check("lit_reset_err", 32'(err_o), 0);

        // Two calls fill the residency without stalling.
        issue(1'b1, 1'b0, n);
        check("lit_call1_stalls", n, 0);
        check("lit_call1_window", 32'(window_o), 1);
        issue(1'b1, 1'b0, n);
        check("lit_call2_stalls", n, 0);
        check("lit_call2_window", 32'(window_o), 2);

        // Overflow call spills window 0.
        issue(1'b1, 1'b0, n);
        check("lit_ovf_stalls", n, 3);
        check("lit_ovf_window", 32'(window_o), 3);
        check("lit_ovf_mem0", 32'(dmem[0]), 32'h1111);
        check("lit_ovf_mem1", 32'(dmem[1]), 32'h2222);

        rf_tab[0][0] = 16'h0000;
        rf_tab[0][1] = 16'h0000;
        issue(1'b0, 1'b1, n);
        check("lit_ret1_stalls", n, 0);
        issue(1'b0, 1'b1, n);
        check("lit_ret2_stalls", n, 0);
        check("lit_ret2_window", 32'(window_o), 1);
        issue(1'b0, 1'b1, n);
        check("lit_unf_stalls", n, 3);
        check("lit_unf_window", 32'(window_o), 0);
        check("lit_unf_reg0", 32'(rf_tab[0][0]), 32'h1111);
        check("lit_unf_reg1", 32'(rf_tab[0][1]), 32'h2222);
        check("lit_unf_nreads", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("lit_unf_read0", 32'(rd_log[0]), 32'hFF01);
            check("lit_unf_read1", 32'(rd_log[1]), 32'hFF00);
        end

        issue(1'b1, 1'b1, n);
        check("lit_both_stalls", n, 0);
        check("lit_both_window", 32'(window_o), 0);
        check("lit_both_err", 32'(err_o), 0);

        // Return with nothing to restore.
        do_reset();
        issue(1'b0, 1'b1, n);
        check("lit_uflow_stalls", n, 0);
        check("lit_uflow_err", 32'(err_o), 1);
        check("lit_uflow_window", 32'(window_o), 0);

        // Asynchronous reset in the middle of a spill.
        do_reset();
        issue(1'b1, 1'b0, n);
        issue(1'b1, 1'b0, n);
        call_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("lit_midrst_stall", 32'(stall_o), 0);
        check("lit_midrst_window", 32'(window_o), 0);
        check("lit_midrst_rf_sel", 32'(rf_sel_o), 0);
        check("lit_midrst_mem_we", 32'(mem_we_o), 0);
        check("lit_midrst_mem_addr", 32'(mem_addr_o), 0);
        call_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b1, 1'b0, n);
        check("lit_postrst_stalls", n, 0);
        check("lit_postrst_window", 32'(window_o), 1);

        // Fill the spill stack to its limit, then overflow it.
        do_reset();
        issue(1'b1, 1'b0, n);
        issue(1'b1, 1'b0, n);
        for (int i = 0; i < SPILLMAX; i++) begin
            issue(1'b1, 1'b0, n);
            check("lit_deep_stalls", n, 3);
        end
        check("lit_deep_err_before", 32'(err_o), 0);
        issue(1'b1, 1'b0, n);
        check("lit_full_stalls", n, 0);
        check("lit_full_err", 32'(err_o), 1);
        check("lit_full_window", 32'(window_o), 2);
`ifdef WINCTRL_STATS_EN
        check("lit_full_spill_cnt", 32'(spill_cnt_o), 32);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
